crc8_check: RTL and testbench
=============================

CRC8_CHECK -- requirements
Module: crc8_check

Interface
REQ-001 SHALL have parameter POLY, default 8'h31, CRC-8 generator x^8+x^5+x^4+1 with the implicit x^8 term omitted.
REQ-002 SHALL have parameter DW, default 32, payload width; frame width is DW+8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, a frame is present on in_frame.
REQ-006 SHALL have port in_ready, output, 1, the block accepts a frame this cycle.
REQ-007 SHALL have port in_frame, input, 40, {payload[31:0], crc[7:0]} as produced by the upstream CRC generator.
REQ-008 SHALL have port out_valid, output, 1, a checked frame is present.
REQ-009 SHALL have port out_ready, input, 1, the consumer accepts the checked frame.
REQ-010 SHALL have port out_data, output, 32, payload of the checked frame.
REQ-011 SHALL have port out_crc_ok, output, 1, the computed CRC equals the received CRC.
REQ-012 SHALL have port err_cnt, output, 16, count of delivered frames with out_crc_ok=0.
REQ-013 SHALL have port err_clr, input, 1, synchronous clear of err_cnt.

Function
REQ-014 SHALL define CRC as MSB-first, init 8'h00, no reflection, no final XOR, over payload bits 31 down to 0; remainder step: fb=rem[7]^bit, rem={rem[6:0],1'b0}^(fb?POLY:0).
REQ-015 SHALL implement FSM states IDLE, CALC and OUT.
REQ-016 SHALL assert in_ready only in IDLE.
REQ-017 SHALL, on in_valid&in_ready in IDLE, capture in_frame, clear rem and the 5-bit bit counter, and go to CALC.
REQ-018 SHALL, in CALC, process exactly one payload bit per cycle, payload[31-cnt], for 32 cycles; on the 32nd cycle it registers out_crc_ok=(rem_next==crc field) and goes to OUT.
REQ-019 SHALL raise out_valid exactly 32 rising edges after the accepting edge.
REQ-020 SHALL hold out_valid, out_data and out_crc_ok stable in OUT until out_valid&out_ready.
REQ-021 SHALL, on the output handshake, return to IDLE; in_ready is high on the following cycle; sustained throughput is one frame per 34 cycles.
REQ-022 SHALL ignore in_valid outside IDLE; upstream holds the frame until it sees in_ready.
REQ-023 SHALL increment err_cnt by 1 on each output handshake with out_crc_ok=0, saturating at 16'hFFFF.
REQ-024 SHALL clear err_cnt to 0 when err_clr=1; err_clr wins over a simultaneous increment.
REQ-025 SHALL never change out_data or out_crc_ok outside the CALC-to-OUT transition.

Reset
REQ-026 SHALL, while rst=1, force state=IDLE, rem=0, cnt=0, out_valid=0, out_data=0, out_crc_ok=0 and err_cnt=0, with in_ready=1 after release.
REQ-027 SHALL discard any frame in CALC or OUT when rst asserts mid-operation; nothing is delivered and err_cnt is not updated.

Structure
REQ-028 SHALL put POLY default, DW, frame width and the state enum (IDLE, CALC, OUT) in shared package crc8_pkg, which the upstream generator also uses.
REQ-029 SHALL place the single-bit remainder step in sub-module crc8_lfsr_step (inputs rem[7:0] and bit; output rem_next[7:0]; combinational).

Verification
REQ-030 SHALL test in_frame=40'h00000001_31 -> out_valid after 32 edges, out_data=32'h00000001, out_crc_ok=1, err_cnt=0.
REQ-031 SHALL test in_frame=40'h00000002_31 (correct CRC 8'h62) -> out_crc_ok=0; err_cnt=1 after the handshake.
REQ-032 SHALL test out_ready held low 10 cycles in OUT -> outputs stable, in_ready=0, and a second in_valid frame is not accepted until after the handshake.
REQ-033 SHALL test err_cnt preloaded via 65535 bad frames plus one more -> err_cnt=16'hFFFF; err_clr together with a bad handshake -> err_cnt=0.
REQ-034 SHALL test rst pulsed at CALC cycle 15 -> out_valid never rises for that frame, err_cnt=0, and the next frame checks correctly.
REQ-035 SHALL test 1000 random payloads from the upstream generator model back-to-back with random out_ready -> all out_crc_ok=1, in-order data, and a single-bit flip in the frame gives out_crc_ok=0.

Source files
------------

// File: rtl/crc8_pkg.sv
// rtl/crc8_pkg.sv - shared CRC-8 constants and checker FSM state type
package crc8_pkg;

   localparam logic [7:0] POLY_DEFAULT = 8'h31;
   localparam int         CRC_DW       = 32;
   localparam int         FRAME_W      = CRC_DW + 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/crc8_check_if.sv
// rtl/crc8_check_if.sv - frame-in / checked-frame-out handshake bundle
interface crc8_check_if
   import crc8_pkg::*;
#(
   parameter int DW = CRC_DW
);
   logic            in_valid;
   logic            in_ready;
   logic [DW+7:0]   in_frame;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic            out_crc_ok;

   modport master (
      output in_valid, in_frame, out_ready,
      input  in_ready, out_valid, out_data, out_crc_ok
   );

   modport slave (
      input  in_valid, in_frame, out_ready,
      output in_ready, out_valid, out_data, out_crc_ok
   );
endinterface

// File: rtl/crc8_lfsr_step.sv
// rtl/crc8_lfsr_step.sv - one MSB-first remainder step of the CRC-8 division
module crc8_lfsr_step
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY = POLY_DEFAULT
) (
   input  logic [7:0] rem,
   input  logic       data_bit,
   output logic [7:0] rem_next
);
   logic fb;

   assign fb       = rem[7] ^ data_bit;
   assign rem_next = {rem[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
endmodule

// File: rtl/crc8_check.sv
// rtl/crc8_check.sv - bit-serial CRC-8 checker: accept frame, verify over DW cycles, deliver with status
module crc8_check
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY = POLY_DEFAULT,
   parameter int         DW   = CRC_DW
) (
   input  logic         clk,
   input  logic         rst,
   crc8_check_if.slave  bus,
   input  logic         err_clr,
   output logic [15:0]  err_cnt
);
   localparam int            CW   = $clog2(DW);
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   state_t          state;
   state_t          state_next;
   logic [DW-1:0]   payload_q;
   logic [7:0]      crc_q;
   logic [7:0]      rem;
   logic [7:0]      rem_next;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   idx;
   logic            data_bit;
   logic [DW-1:0]   out_data;
   logic            out_crc_ok;
   logic            in_ready;
   logic            out_valid;
   logic            deliver;

   assign idx      = LAST - cnt;
   assign data_bit = payload_q[idx];

   crc8_lfsr_step #(.POLY(POLY)) u_step (
      .rem      (rem),
      .data_bit (data_bit),
      .rem_next (rem_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_next = CALC;
         end
         CALC: begin
            if (cnt == LAST) state_next = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign deliver = out_valid & bus.out_ready;

   // Outputs are only loaded on the final CALC cycle so they stay frozen while OUT stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         payload_q  <= '0;
         crc_q      <= '0;
         rem        <= '0;
         cnt        <= '0;
         out_data   <= '0;
         out_crc_ok <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  payload_q <= bus.in_frame[DW+7:8];
                  crc_q     <= bus.in_frame[7:0];
                  rem       <= '0;
                  cnt       <= '0;
               end
            end
            CALC: begin
               rem <= rem_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  out_data   <= payload_q;
                  out_crc_ok <= (rem_next == crc_q);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_cnt <= '0;
      else if (err_clr)
         err_cnt <= '0;
      else if (deliver && !out_crc_ok && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_data   = out_data;
   assign bus.out_crc_ok = out_crc_ok;
endmodule

// File: tb/tb_crc8_check.sv
// tb/tb_crc8_check.sv - randomized self-checking bench for crc8_check against a polynomial-division model
module tb_crc8_check;
   import crc8_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        err_clr = 1'b0;
   logic [15:0] err_cnt;
   int          n_checks = 0;
   int          n_fail = 0;
   int          exp_err = 0;
   logic [31:0] exp_q[$];

   crc8_check_if #(.DW(CRC_DW)) bus ();

   crc8_check dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .err_clr (err_clr),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Remainder of payload*x^8 divided by the full generator, by XOR long division.
   function automatic logic [7:0] crc_ref(input logic [31:0] p);
      logic [39:0] v;
      v = {p, 8'h00};
      for (int i = 39; i >= 8; i--)
         if (v[i]) v = v ^ (40'h131 << (i - 8));
      return v[7:0];
   endfunction

   task automatic send(input logic [39:0] f, output bit acc);
      int t;
      t = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_frame = f;
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      acc = bus.in_ready;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!bus.out_valid && lat < 64);
      if (!bus.out_valid) lat = -1;
   endtask

   task automatic do_frame(input logic [39:0] f, input bit clr);
      bit acc;
      int lat;
      logic exp_ok;
      exp_ok = (crc_ref(f[39:8]) == f[7:0]);
      send(f, acc);
      check("accept", acc, 1);
      wait_out(lat);
      check("latency", lat, 32);
      check("out_data", bus.out_data, f[39:8]);
      check("out_crc_ok", bus.out_crc_ok, exp_ok);
      bus.out_ready = 1'b1;
      err_clr = clr;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      err_clr = 1'b0;
      if (clr) exp_err = 0;
      else if (!exp_ok && exp_err < 65535) exp_err++;
      check("err_cnt", err_cnt, exp_err);
      check("in_ready_after", bus.in_ready, 1);
      check("out_valid_after", bus.out_valid, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] p, p2;
      logic [39:0] f;
      bit acc, seen;
      int lat, got, guard;

      bus.in_valid  = 1'b0;
      bus.in_frame  = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_crc_ok", bus.out_crc_ok, 0);
      check("rst_err_cnt", err_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);

      do_frame({32'h00000001, 8'h31}, 1'b0);
      do_frame({32'h00000002, 8'h31}, 1'b0);

      // Output stall with a second frame waiting upstream.
      p  = $urandom;
      p2 = $urandom;
      send({p, crc_ref(p)}, acc);
      wait_out(lat);
      check("stall_latency", lat, 32);
      bus.in_valid = 1'b1;
      bus.in_frame = {p2, crc_ref(p2)};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_out_valid", bus.out_valid, 1);
         check("stall_out_data", bus.out_data, p);
         check("stall_out_crc_ok", bus.out_crc_ok, 1);
         check("stall_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      check("stall_release_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      check("second_taken", bus.in_ready, 0);
      wait_out(lat);
      check("second_latency", lat, 32);
      check("second_data", bus.out_data, p2);
      check("second_ok", bus.out_crc_ok, 1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;

      // Reset in the middle of a bad frame.
      send({32'h00000002, 8'h31}, acc);
      repeat (15) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("midrst_err_cnt", err_cnt, 0);
      rst = 1'b0;
      exp_err = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 if (bus.out_valid) seen = 1'b1;
      end
      check("midrst_no_output", seen, 0);
      check("midrst_err_after", err_cnt, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      p = $urandom;
      do_frame({p, crc_ref(p)}, 1'b0);

      // Back-to-back generator traffic against a random consumer.
      got = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [31:0] q;
               bit a;
               q = $urandom;
               exp_q.push_back(q);
               send({q, crc_ref(q)}, a);
               if (!a) check("rand_accept", a, 1);
            end
         end
         begin
            guard = 0;
            while (got < 1000 && guard < 60000) begin
               @(negedge clk);
               guard++;
               bus.out_ready = 1'($urandom_range(0, 1));
               if (bus.out_valid && bus.out_ready) begin
                  if (exp_q.size() == 0) begin
                     check("rand_unexpected", 1, 0);
                  end else begin
                     p = exp_q.pop_front();
                     check("rand_data", bus.out_data, p);
                     check("rand_ok", bus.out_crc_ok, 1);
                  end
                  got++;
               end
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
         end
      join
      check("rand_count", got, 1000);
      check("rand_err_cnt", err_cnt, exp_err);

      for (int i = 0; i < 8; i++) begin
         p = $urandom;
         f = {p, crc_ref(p)};
         f[$urandom_range(0, 39)] ^= 1'b1;
         do_frame(f, 1'b0);
      end

      // Saturation: preload just below the ceiling, then two more bad frames.
      force dut.err_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.err_cnt;
      exp_err = 65534;
      do_frame({32'h00000002, 8'h31}, 1'b0);
      do_frame({32'h00000003, 8'h00}, 1'b0);
      do_frame({32'h00000004, 8'h00}, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
